// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer and its timers.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        BACKOFF,
        RESP
    } seq_state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } i2c_cmd_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable up-counter with clear/enable and a terminal-count compare against tc_val.
module i2c_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // clr outranks load, load outranks counting
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/i2c_cmd_seq.sv
// Command sequencer in front of i2c_m: single-command handshake, NACK retry with
// backoff, start/transfer timeouts, and a registered valid/ready response.
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter int MAX_RETRY   = 2,
    parameter int BACKOFF_CYC = 64,
    parameter int START_TMO   = 32,
    parameter int XFER_TMO    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic [1:0] rsp_retries,
    output logic       m_en,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_data_wr,
    input  logic [7:0] m_data_r,
    input  logic       m_ack_error,
    input  logic       m_busy,
    output logic       seq_idle
);

    localparam int TW = $clog2(max3(START_TMO, XFER_TMO, BACKOFF_CYC)) + 1;
    // Wide enough that the saturation compare against 3 is never degenerate
    localparam int RW = $clog2(MAX_RETRY + 2) + 2;

    localparam logic [TW-1:0] START_TC = TW'(START_TMO - 1);
    localparam logic [TW-1:0] XFER_TC  = TW'(XFER_TMO - 1);
    localparam logic [TW-1:0] BO_TC    = TW'(BACKOFF_CYC - 1);

    function automatic logic [1:0] sat_retries(input logic [RW-1:0] r);
        if (r > RW'(3)) begin
            return 2'd3;
        end
        return r[1:0];
    endfunction

    seq_state_t      state, state_nxt;
    i2c_cmd_t        cmd_q, cmd_nxt;
    logic [RW-1:0]   retry_q, retry_nxt;
    logic [7:0]      rdata_nxt;
    logic [1:0]      status_nxt;
    logic [1:0]      retries_nxt;

    logic            tmr_clr;
    logic            st_en, st_tc;
    logic            bo_en, bo_tc;
    logic [TW-1:0]   st_tc_val;

    // Any state change restarts both timers, so each state sees a fresh count
    assign tmr_clr   = (state_nxt != state);
    assign st_en     = (state == ISSUE) || (state == XFER);
    assign bo_en     = (state == BACKOFF);
    assign st_tc_val = (state == XFER) ? XFER_TC : START_TC;

    i2c_seq_timer #(.W(TW)) u_st_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (st_en),
        .load     (1'b0),
        .load_val ('0),
        .tc_val   (st_tc_val),
        .tc       (st_tc)
    );

    i2c_seq_timer #(.W(TW)) u_bo_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (bo_en),
        .load     (1'b0),
        .load_val ('0),
        .tc_val   (BO_TC),
        .tc       (bo_tc)
    );

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd_q;
        retry_nxt   = retry_q;
        rdata_nxt   = rsp_rdata;
        status_nxt  = rsp_status;
        retries_nxt = rsp_retries;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.rw    = cmd_rw;
                    cmd_nxt.wdata = cmd_wdata;
                    retry_nxt     = '0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // busy rising takes priority over a coincident start timeout
                if (m_busy) begin
                    state_nxt = XFER;
                end else if (st_tc) begin
                    status_nxt  = ST_TMO;
                    rdata_nxt   = 8'h00;
                    retries_nxt = sat_retries(retry_q);
                    state_nxt   = RESP;
                end
            end
            XFER: begin
                if (!m_busy) begin
                    if (!m_ack_error) begin
                        status_nxt  = ST_OK;
                        rdata_nxt   = cmd_q.rw ? m_data_r : 8'h00;
                        retries_nxt = sat_retries(retry_q);
                        state_nxt   = RESP;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_nxt = retry_q + 1'b1;
                        state_nxt = BACKOFF;
                    end else begin
                        status_nxt  = ST_NACK;
                        rdata_nxt   = 8'h00;
                        retries_nxt = sat_retries(retry_q);
                        state_nxt   = RESP;
                    end
                end else if (st_tc) begin
                    status_nxt  = ST_TMO;
                    rdata_nxt   = 8'h00;
                    retries_nxt = sat_retries(retry_q);
                    state_nxt   = RESP;
                end
            end
            BACKOFF: begin
                if (bo_tc) begin
                    state_nxt = ISSUE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they change with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            retry_q     <= '0;
            cmd_ready   <= 1'b1;
            seq_idle    <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_status  <= ST_OK;
            rsp_retries <= 2'd0;
            m_en        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            retry_q     <= retry_nxt;
            cmd_ready   <= (state_nxt == IDLE);
            seq_idle    <= (state_nxt == IDLE);
            rsp_valid   <= (state_nxt == RESP);
            rsp_rdata   <= rdata_nxt;
            rsp_status  <= status_nxt;
            rsp_retries <= retries_nxt;
            m_en        <= (state_nxt == ISSUE);
        end
    end

    assign m_addr    = cmd_q.addr;
    assign m_rw      = cmd_q.rw;
    assign m_data_wr = cmd_q.wdata;

endmodule
